// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift_arbiter slice.
package shift_arb_pkg;

   // Requester id width: two ports, so one bit.
   localparam int ID_W = 1;

   // Operand width the op_t record is built for; the top's M must match it.
   localparam int OP_W = 8;

   // Arbiter sequence: pick a port, latch its operands, shift, respond.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      EXEC  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Operand pair held for the shifter while an operation is in flight.
   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
   } op_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Two-port request bus plus the shared, id-tagged response bus of shift_arbiter.
interface shift_arbiter_if
   import shift_arb_pkg::*;
#(
   parameter int M     = 8,
   parameter int CNT_W = 8
);

   // Requester side
   logic              i_req0;
   logic [M-1:0]      i_argA0;
   logic [M-1:0]      i_argB0;
   logic              i_req1;
   logic [M-1:0]      i_argA1;
   logic [M-1:0]      i_argB1;

   // Arbiter side
   logic [1:0]        o_gnt;
   logic              o_valid;
   logic [ID_W-1:0]   o_id;
   logic [M-1:0]      o_y;
   logic              o_error;
   logic              o_busy;
   logic [CNT_W-1:0]  o_err_cnt;

   // Requesters (and the bench) drive requests and observe responses.
   modport master (
      output i_req0, i_argA0, i_argB0, i_req1, i_argA1, i_argB1,
      input  o_gnt, o_valid, o_id, o_y, o_error, o_busy, o_err_cnt
   );

   // The arbiter consumes requests and drives responses.
   modport slave (
      input  i_req0, i_argA0, i_argB0, i_req1, i_argA1, i_argB1,
      output o_gnt, o_valid, o_id, o_y, o_error, o_busy, o_err_cnt
   );

endinterface

// File: rtl/bit_shift.sv
// Shared shift datapath: left shift with a signed amount; negative amounts flag ERROR.
module bit_shift #(
   parameter int M = 8
) (
   input  logic [M-1:0] argA,
   input  logic [M-1:0] argB,
   output logic [M-1:0] o_y,
   output logic         ERROR
);

   // Negative amount (sign bit set) is rejected with a zero result.
   always_comb begin
      ERROR = argB[M-1];
      o_y   = ERROR ? '0 : (argA << argB);
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one bit_shift between two requesters, with an
// id-tagged registered response and a saturating error counter.
module shift_arbiter
   import shift_arb_pkg::*;
#(
   parameter int M     = OP_W,
   parameter int CNT_W = 8
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   shift_arbiter_if.slave bus
);

   state_t             state_q, state_d;
   logic [ID_W-1:0]    sel_id_q, sel_id_d;
   logic [ID_W-1:0]    last_id_q, last_id_d;
   op_t                op_q, op_d;
   logic [1:0]         gnt_q, gnt_d;
   logic               valid_q, valid_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [M-1:0]       y_q, y_d;
   logic               error_q, error_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [M-1:0]       sh_y;
   logic               sh_error;

   // The single shared shifter always sees the latched operands.
   bit_shift #(.M(M)) u_bit_shift (
      .argA  (op_q.a),
      .argB  (op_q.b),
      .o_y   (sh_y),
      .ERROR (sh_error)
   );

   // Next-state and datapath control for the IDLE/GRANT/EXEC/RESP sequence.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
      state_d   = state_q;
      sel_id_d  = sel_id_q;
      last_id_d = last_id_q;
      op_d      = op_q;
      gnt_d     = 2'b00;
      valid_d   = 1'b0;
      id_d      = id_q;
      y_d       = y_q;
      error_d   = error_q;
      cnt_d     = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (bus.i_req0 || bus.i_req1) begin
               // Contention goes to the port that was not served last.
               if (bus.i_req0 && bus.i_req1) begin
                  sel_id_d = ~last_id_q;
               end else begin
                  sel_id_d = bus.i_req1 ? ID_W'(1) : ID_W'(0);
               end
               gnt_d   = (sel_id_d == ID_W'(1)) ? 2'b10 : 2'b01;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (sel_id_q == ID_W'(1)) begin
               op_d.a = bus.i_argA1;
               op_d.b = bus.i_argB1;
            end else begin
               op_d.a = bus.i_argA0;
               op_d.b = bus.i_argB0;
            end
            state_d = EXEC;
         end
         EXEC: begin
            y_d     = sh_y;
            error_d = sh_error;
            id_d    = sel_id_q;
            valid_d = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            last_id_d = sel_id_q;
            if (error_q && (cnt_q != {CNT_W{1'b1}})) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         sel_id_q  <= '0;
         last_id_q <= ID_W'(1);
         op_q      <= '0;
         gnt_q     <= 2'b00;
         valid_q   <= 1'b0;
         id_q      <= '0;
         y_q       <= '0;
         error_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         state_q   <= state_d;
         sel_id_q  <= sel_id_d;
         last_id_q <= last_id_d;
         op_q      <= op_d;
         gnt_q     <= gnt_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         y_q       <= y_d;
         error_q   <= error_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.o_gnt     = gnt_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_id      = id_q;
   assign bus.o_y       = y_q;
   assign bus.o_error   = error_q;
   assign bus.o_busy    = (state_q != IDLE);
   assign bus.o_err_cnt = cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter.
module tb_shift_arbiter;

   logic clk;
   logic rst_n;

   int n_asserts;
   int n_fail;

   shift_arbiter_if #(.M(8), .CNT_W(8)) bus ();

   shift_arbiter #(.M(8), .CNT_W(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance until o_valid (at least one edge), bounded; returns edges waited.
   task automatic wait_valid(input string tag, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.o_valid && n < 12);
      check({tag, " valid"}, 32'(bus.o_valid), 32'd1);
   endtask

   // One isolated operation from IDLE, with grant, latency, response and drop.
   task automatic run_op(input logic port, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_y, input logic exp_err, input string tag);
      int n;
      if (port) begin
         bus.i_req1 = 1'b1; bus.i_argA1 = a; bus.i_argB1 = b;
      end else begin
         bus.i_req0 = 1'b1; bus.i_argA0 = a; bus.i_argB0 = b;
      end
      @(posedge clk); #1;
      check({tag, " gnt"}, 32'(bus.o_gnt), port ? 32'h2 : 32'h1);
      wait_valid(tag, n);
      check({tag, " latency"}, 32'(n), 32'd2);
      check({tag, " id"}, 32'(bus.o_id), 32'(port));
      check({tag, " y"}, 32'(bus.o_y), 32'(exp_y));
      check({tag, " error"}, 32'(bus.o_error), 32'(exp_err));
      bus.i_req0 = 1'b0;
      bus.i_req1 = 1'b0;
      @(posedge clk); #1;
      check({tag, " valid drop"}, 32'(bus.o_valid), 32'd0);
      check({tag, " idle"}, 32'(bus.o_busy), 32'd0);
   endtask

   initial begin
      int n;
      logic [7:0] exp_cnt;
      n_asserts = 0;
      n_fail    = 0;

      rst_n       = 1'b0;
      bus.i_req0  = 1'b0; bus.i_argA0 = '0; bus.i_argB0 = '0;
      bus.i_req1  = 1'b0; bus.i_argA1 = '0; bus.i_argB1 = '0;
      #1;
      check("reset gnt",     32'(bus.o_gnt),     32'd0);
      check("reset valid",   32'(bus.o_valid),   32'd0);
      check("reset y",       32'(bus.o_y),       32'd0);
      check("reset error",   32'(bus.o_error),   32'd0);
      check("reset busy",    32'(bus.o_busy),    32'd0);
      check("reset err_cnt", 32'(bus.o_err_cnt), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle after reset", 32'(bus.o_busy), 32'd0);

      // Basic shift on port 0, and values held after the response.
      run_op(1'b0, 8'd8, 8'd2, 8'd32, 1'b0, "single");
      check("single err_cnt", 32'(bus.o_err_cnt), 32'd0);
      check("single y hold",  32'(bus.o_y),       32'd32);

      // Negative shift amount on port 1.
      run_op(1'b1, 8'd8, 8'hFB, 8'd0, 1'b1, "error");
      check("error err_cnt", 32'(bus.o_err_cnt), 32'd1);

      // Negative argA is legal.
      run_op(1'b0, 8'hF8, 8'd1, 8'hF0, 1'b0, "negA");
      check("negA err_cnt", 32'(bus.o_err_cnt), 32'd1);

      // Shift amount boundaries: top bit, full width, largest positive.
      run_op(1'b1, 8'd1,  8'd7,   8'h80, 1'b0, "shift7");
      run_op(1'b0, 8'hFF, 8'd8,   8'h00, 1'b0, "shift8");
      run_op(1'b1, 8'h5A, 8'h7F,  8'h00, 1'b0, "shift127");

      // Contention from reset release: both ports held, strict alternation.
      rst_n = 1'b0;
      #1;
      check("reset2 err_cnt", 32'(bus.o_err_cnt), 32'd0);
      bus.i_req0 = 1'b1; bus.i_argA0 = 8'd3; bus.i_argB0 = 8'd1;
      bus.i_req1 = 1'b1; bus.i_argA1 = 8'd5; bus.i_argB1 = 8'd2;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_valid("contend", n);
         check("contend gap", 32'(n), (i == 0) ? 32'd3 : 32'd4);
         check("contend id",  32'(bus.o_id), 32'(i % 2));
         check("contend y",   32'(bus.o_y), (i % 2 == 0) ? 32'd6 : 32'd20);
      end
      bus.i_req0 = 1'b0;
      bus.i_req1 = 1'b0;
      @(posedge clk); #1;
      check("contend idle", 32'(bus.o_busy), 32'd0);

      // Error counter saturation.
      exp_cnt = 8'd0;
      for (int i = 0; i < 300; i++) begin
         run_op(1'b0, 8'd1, 8'hFF, 8'd0, 1'b1, "sat");
         if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
         check("sat err_cnt", 32'(bus.o_err_cnt), 32'(exp_cnt));
      end
      check("sat final", 32'(bus.o_err_cnt), 32'd255);

      // Reset during EXEC aborts the operation silently.
      run_op(1'b0, 8'd1, 8'd3, 8'd8, 1'b0, "pre_abort");
      bus.i_req1 = 1'b1; bus.i_argA1 = 8'd2; bus.i_argB1 = 8'd1;
      @(posedge clk); #1;
      check("abort gnt", 32'(bus.o_gnt), 32'h2);
      @(posedge clk); #1;
      check("abort in exec", 32'(bus.o_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort y",       32'(bus.o_y),       32'd0);
      check("abort busy",    32'(bus.o_busy),    32'd0);
      check("abort valid",   32'(bus.o_valid),   32'd0);
      check("abort gnt0",    32'(bus.o_gnt),     32'd0);
      check("abort err_cnt", 32'(bus.o_err_cnt), 32'd0);
      bus.i_req1 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("abort no valid", 32'(bus.o_valid), 32'd0);
      end

      // After reset, port 0 wins the first contention, then port 1 is served.
      bus.i_req0 = 1'b1; bus.i_argA0 = 8'd4; bus.i_argB0 = 8'd1;
      bus.i_req1 = 1'b1; bus.i_argA1 = 8'd9; bus.i_argB1 = 8'd3;
      @(posedge clk); #1;
      check("post gnt", 32'(bus.o_gnt), 32'h1);
      wait_valid("post0", n);
      check("post0 id", 32'(bus.o_id), 32'd0);
      check("post0 y",  32'(bus.o_y),  32'd8);
      bus.i_req0 = 1'b0;
      wait_valid("post1", n);
      check("post1 id", 32'(bus.o_id), 32'd1);
      check("post1 y",  32'(bus.o_y),  32'h48);
      bus.i_req1 = 1'b0;
      @(posedge clk); #1;
      check("post idle", 32'(bus.o_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one `bit_shift` datapath instance between two requesters (port 0, port 1) inside exe_unit_3.
- Arbitrates round-robin, latches the winner's operands and drives them into `bit_shift`.
- Registers `o_y`/ERROR and returns them on a shared response bus tagged with the requester id.
- Keeps a saturating count of ERROR results for status readback over APB.

Parameters:
- M, 8, operand/result width; passed through to `bit_shift`.
- CNT_W, 8, width of the error counter.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req0  input  1  port 0 request; held high until its response.
- i_argA0  input  M  port 0 value to shift; stable while i_req0 is high.
- i_argB0  input  M  port 0 shift amount, signed; stable while i_req0 is high.
- i_req1, i_argA1, i_argB1: as above, for port 1.
- o_gnt  output  2  one-hot grant pulse, 1 cycle, in the operand-latch cycle.
- o_valid  output  1  response valid, 1-cycle pulse.
- o_id  output  1  requester owning the current response.
- o_y  output  M  registered shifter result.
- o_error  output  1  registered shifter ERROR.
- o_busy  output  1  high in any state other than IDLE.
- o_err_cnt  output  CNT_W  saturating count of responses with o_error=1.

Behaviour:
- Reset, asynchronous on i_rst_n low: all outputs 0, state=IDLE, last_id=1, operand registers 0.
- bit_shift contract relied on:
  - combinational o_y = argA << argB, truncated to M bits;
  - ERROR=1 and o_y=0 when argB is negative as signed M-bit.
- FSM states: IDLE, GRANT, EXEC, RESP.
- IDLE:
  - no request: stay in IDLE.
  - exactly one request: select it.
  - both request: select the id != last_id.
  - on a selection, next state is GRANT.
- GRANT:
  - latch the selected argA/argB into op registers; sel_id <= selected id.
  - o_gnt[sel] = 1 this cycle; next state EXEC.
- EXEC:
  - op registers drive `bit_shift`.
  - At the clock edge: o_y <= shifter o_y, o_error <= ERROR, o_id <= sel_id. Next state RESP.
- RESP:
  - o_valid = 1 for exactly one cycle; last_id <= sel_id.
  - If o_error=1, o_err_cnt increments unless already at all-ones (saturate, no wrap).
  - Next state IDLE.
- Latency: request sampled high in IDLE at edge k gives o_valid high in the cycle after edge k+2.
- Throughput: 1 operation per 4 cycles.
- o_y, o_error and o_id hold their values after RESP until the next EXEC; only o_valid qualifies them.
- A requester must drop its request in the cycle after o_valid with its id. A request still high in IDLE is treated as a new request.
- Request dropped or operands changed after GRANT: ignored; the operation completes on the latched operands and a response is still issued.
- Request asserted while busy: waits; sampled at the next IDLE.
- Fairness: two continuously asserted requests alternate 0,1,0,1...; the first grant after reset goes to port 0.
- Reset mid-operation: immediate return to IDLE with outputs 0. No o_valid is emitted for the aborted operation. o_err_cnt is cleared.
- Negative argA is legal (no error); only negative argB sets o_error.

Decomposition:
- Package `shift_arb_pkg`:
  - `state_t` enum {IDLE, GRANT, EXEC, RESP};
  - localparam ID_W=1;
  - typedef `op_t` struct {logic [M-1:0] a; logic [M-1:0] b;}.
- Sub-module: exactly one `bit_shift` instance (existing, unmodified), fed from the op registers.
- Arbiter select logic stays inline; no further sub-modules.

Test Plan:
- Single request: i_req0=1, A=8, B=2 -> o_gnt=01 in cycle 1; o_valid=1, o_id=0, o_y=32, o_error=0 three cycles after the request; o_err_cnt=0.
- Error case: i_req1=1, A=8, B=-5 (8'hFB) -> o_valid with o_id=1, o_y=0, o_error=1; o_err_cnt=1.
- Negative A: i_req0=1, A=-8 (8'hF8), B=1 -> o_y=8'hF0, o_error=0.
- Contention: i_req0 and i_req1 held high from reset release with distinct operands -> responses in id order 0,1,0,1, each 4 cycles apart, each o_y matching its own operands.
- Saturation: 300 consecutive requests with B=-1 -> o_err_cnt stops at 255 and does not wrap to 0.
- Reset mid-op: assert i_rst_n=0 during EXEC -> all outputs 0 immediately, no o_valid afterwards. After release, a new request completes normally and port 0 wins the first contention.
